seq_detect_multi: RTL and testbench
===================================

// Module: seq_detect_multi
// PURPOSE
//  Parametrised, multi-channel serial pattern detector. Generalises the fixed single-bit
//  sequence-detector FSMs: programmable pattern and length, overlap or non-overlap mode,
//  and N independent channels sharing one pattern register.
//  Sits beside the existing detectors; any stream source drives x[], and hit[] feeds
//  downstream control/monitor logic.
// PARAMETERS
//  N_CH      4        number of independent serial input channels (1..16)
//  PAT_LEN   4        pattern length in bits (2..16)
//  PAT_RESET 4'b1011  pattern loaded at reset (PAT_LEN bits)
//  CNT_W     8        per-channel hit-counter width (used only with HIT_COUNT_EN)
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              asynchronous, active-low reset
//  en           in   1              sample enable; x[] sampled only when en=1
//  x            in   N_CH           serial data, one bit per channel
//  cfg_load     in   1              load cfg_pattern/cfg_overlap, clear all channel state
//  cfg_pattern  in   PAT_LEN        new pattern; bit [PAT_LEN-1] = first bit received
//  cfg_overlap  in   1              1=overlapping matches allowed, 0=non-overlapping
//  hit          out  N_CH           registered one-cycle match pulse per channel
//  hit_cnt      out  N_CH*CNT_W     per-channel hit count, ch i at [i*CNT_W +: CNT_W] (macro only)
// BEHAVIOUR
//  - Reset (rst=0, async): hit=0, all histories=0, fill counts=0, pattern=PAT_RESET,
//    overlap=1, hit_cnt=0. Reset mid-stream discards all partial matches.
//  - Per channel: PAT_LEN-bit shift history hist (new bit shifts into [0]), plus fill
//    count fcnt (width $clog2(PAT_LEN+1), saturates at PAT_LEN).
//  - Channel FSM: FILL (fcnt<PAT_LEN) -> ARMED (fcnt==PAT_LEN).
//    A match is evaluated on the next history value: {hist[PAT_LEN-2:0], x[i]} == pattern,
//    with fcnt+1 >= PAT_LEN.
//  - Latency: hit[i] is asserted in the cycle after the edge that samples the completing
//    bit (Moore, registered). It is a single-cycle pulse.
//  - Overlap=1: history is kept after a match; back-to-back and shared-prefix hits are
//    allowed.
//  - Overlap=0: on a match, fcnt clears to 0 (FILL). The next hit needs PAT_LEN fresh bits.
//  - en=0: history, fcnt and counters hold; hit=0 on the next edge.
//  - cfg_load=1 (has priority over en): on the edge, pattern<=cfg_pattern,
//    overlap<=cfg_overlap, all hist/fcnt cleared, hit<=0. x[] is ignored that cycle.
//    hit_cnt is NOT cleared.
//  - Channels are fully independent; simultaneous hits on several channels are all reported.
// CONFIGURATION
//  - HIT_COUNT_EN defined:
//    - Per-channel CNT_W-bit counter increments on each hit pulse and saturates at
//      2^CNT_W-1 (no wrap).
//    - Cleared only by rst.
//    - hit_cnt port present.
//  - HIT_COUNT_EN undefined: no counters and no hit_cnt port. hit[] behaviour is identical.
// TESTING
//  1. Defaults, ch0 overlap=1, en=1, x=1,0,1,1,0,1,1 -> hit[0] pulses the cycle after
//     bit 4 and the cycle after bit 7. Other channels (x=0) stay 0.
//  2. cfg_load pattern=4'b1011, overlap=0, same stream -> single hit after bit 4,
//     none after bit 7.
//  3. ch0 sends 1,0,1 then rst low 1 cycle, then 1 -> no hit. Then 0,1,1 -> hit after the
//     4th post-reset bit.
//  4. Stream 1,0,1 with en=0 for 3 cycles before the final 1 -> exactly one hit, one cycle
//     after the final 1 is sampled. hit=0 throughout the en=0 gap.
//  5. ch1 x=1,0,1,1 while ch2 x=1,0,1,1 offset by 2 cycles -> hit[1] and hit[2] each pulse
//     once, 2 cycles apart. cfg_load mid-pattern on ch3 -> no hit on ch3.
//  6. HIT_COUNT_EN, CNT_W=2, overlap=1, pattern 4'b1111, x held 1 for 10 bits ->
//     7 hits; hit_cnt[0] reads 3 and stays 3.

Source files
------------

// File: rtl/seq_detect_multi.sv
// ---------------------------------------------------------------------------
// seq_detect_multi
//
// Multi-channel serial pattern detector. Each of N_CH channels shifts its
// serial input into a private PAT_LEN-bit history. A registered one-cycle
// pulse on hit[i] is raised when the newest PAT_LEN bits equal the shared
// pattern register. The pattern and the overlap mode are loaded at run time
// through cfg_load.
//
// Optional feature macro: HIT_COUNT_EN
//   defined   : per-channel saturating hit counters, exported on hit_cnt
//   undefined : no counters and no hit_cnt port; hit[] behaves identically
//
// Ports
//   clk          in   1            system clock, rising edge
//   rst          in   1            asynchronous, active-low reset
//   en           in   1            sample enable; x[] sampled only when en=1
//   x            in   N_CH         serial data, one bit per channel
//   cfg_load     in   1            load pattern/overlap, clear channel state
//   cfg_pattern  in   PAT_LEN      new pattern, bit [PAT_LEN-1] received first
//   cfg_overlap  in   1            1 = overlapping matches, 0 = non-overlapping
//   hit          out  N_CH         registered one-cycle match pulse
//   dbg_armed    out  N_CH         channel FSM state (1 = ARMED, 0 = FILL)
//   hit_cnt      out  N_CH*CNT_W   per-channel hit count (HIT_COUNT_EN only)
//
// Handshake: there is no flow control. A bit is consumed on every rising
// edge where en=1 and cfg_load=0; cfg_load=1 takes priority and the x[] of
// that cycle is discarded.
// ---------------------------------------------------------------------------
module seq_detect_multi #(
  parameter int                  N_CH      = 4,
  parameter int                  PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0]  PAT_RESET = 4'b1011,
  parameter int                  CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_CH-1:0]      x,
  input  logic                 cfg_load,
  input  logic [PAT_LEN-1:0]   cfg_pattern,
  input  logic                 cfg_overlap,
  output logic [N_CH-1:0]      hit,
  output logic [N_CH-1:0]      dbg_armed
`ifdef HIT_COUNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] hit_cnt
`endif
);

  localparam int FCNT_W = $clog2(PAT_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(PAT_LEN);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } ch_state_e;

  // Elaboration-time guard on the supported parameter ranges.
  if (N_CH < 1 || N_CH > 16 || PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_multi: parameter out of range");
  end

  // Shared configuration
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;

  // Per-channel state
  logic [PAT_LEN-1:0] hist_q   [N_CH];
  logic [PAT_LEN-1:0] hist_d   [N_CH];
  logic [PAT_LEN-1:0] hist_nxt [N_CH];
  logic [FCNT_W-1:0]  fcnt_q   [N_CH];
  logic [FCNT_W-1:0]  fcnt_d   [N_CH];
  ch_state_e          state_q  [N_CH];
  ch_state_e          state_d  [N_CH];
  logic [N_CH-1:0]    hit_q, hit_d;
  logic [N_CH-1:0]    match;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    match     = '0;
    hit_d     = '0;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
    end

    for (int i = 0; i < N_CH; i++) begin
      hist_nxt[i] = {hist_q[i][PAT_LEN-2:0], x[i]};
      hist_d[i]   = hist_q[i];
      fcnt_d[i]   = fcnt_q[i];

      if (cfg_load) begin
        hist_d[i] = '0;
        fcnt_d[i] = '0;
      end else if (en) begin
        hist_d[i] = hist_nxt[i];
        // A match needs a full window: either already armed, or this bit
        // is the one that completes the window.
        match[i] = (hist_nxt[i] == pattern_q) &&
                   ((state_q[i] == S_ARMED) || (fcnt_q[i] == FCNT_MAX - 1'b1));
        if (match[i] && !overlap_q) begin
          // Non-overlapping: the matched bits cannot seed the next match.
          fcnt_d[i] = '0;
        end else if (state_q[i] == S_FILL) begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end

      state_d[i] = (fcnt_d[i] == FCNT_MAX) ? S_ARMED : S_FILL;
    end

    hit_d = match;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= PAT_RESET;
      overlap_q <= 1'b1;
      hit_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i]  <= '0;
        fcnt_q[i]  <= '0;
        state_q[i] <= S_FILL;
      end
    end else begin
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      hit_q     <= hit_d;
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i]  <= hist_d[i];
        fcnt_q[i]  <= fcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign hit = hit_q;

  always_comb begin
    dbg_armed = '0;
    for (int i = 0; i < N_CH; i++) begin
      dbg_armed[i] = (state_q[i] == S_ARMED);
    end
  end

`ifdef HIT_COUNT_EN
  // -------------------------------------------------------------------------
  // Saturating hit counters. They advance on the same edge that raises hit,
  // so hit_cnt already includes a pulse while that pulse is visible.
  // cfg_load leaves them untouched; only rst clears them.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hit_d[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_multi.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_multi
//
// Directed scenarios followed by a randomized run. The reference model keeps,
// per channel, the list of bits received since the last clear point (reset,
// cfg_load, or a non-overlapping match) and declares a hit whenever that list
// holds at least PAT_LEN bits and its newest PAT_LEN bits spell the pattern.
// ---------------------------------------------------------------------------
module tb_seq_detect_multi;

  localparam int N_CH    = 4;
  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 2;
  localparam logic [PAT_LEN-1:0] PAT_RESET = 4'b1011;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [N_CH-1:0]      x;
  logic                 cfg_load;
  logic [PAT_LEN-1:0]   cfg_pattern;
  logic                 cfg_overlap;
  logic [N_CH-1:0]      hit;
  logic [N_CH-1:0]      dbg_armed;
`ifdef HIT_COUNT_EN
  logic [N_CH*CNT_W-1:0] hit_cnt;
`endif

  always #5 clk = ~clk;

  seq_detect_multi #(
    .N_CH      (N_CH),
    .PAT_LEN   (PAT_LEN),
    .PAT_RESET (PAT_RESET),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x           (x),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .hit         (hit),
    .dbg_armed   (dbg_armed)
`ifdef HIT_COUNT_EN
    ,
    .hit_cnt     (hit_cnt)
`endif
  );

  // -------------------------------------------------------------------------
  // Scoreboard and reference model
  // -------------------------------------------------------------------------
  int n_assert = 0;
  int n_fail   = 0;

  logic [N_CH-1:0]    exp_q[$];
  bit                 m_bits[N_CH][$];
  logic [PAT_LEN-1:0] m_pat;
  bit                 m_ovl;
  int                 m_cnt[N_CH];
  int                 tally[N_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = PAT_RESET;
    m_ovl = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N_CH; i++) begin
      m_bits[i].delete();
      m_cnt[i] = 0;
    end
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_edge();
    logic [N_CH-1:0]    e_hit;
    logic [PAT_LEN-1:0] win;
    int                 sz;
    e_hit = '0;
    if (cfg_load) begin
      m_pat = cfg_pattern;
      m_ovl = cfg_overlap;
      for (int i = 0; i < N_CH; i++) m_bits[i].delete();
    end else if (en) begin
      for (int i = 0; i < N_CH; i++) begin
        m_bits[i].push_back(x[i]);
        if (m_bits[i].size() > PAT_LEN) void'(m_bits[i].pop_front());
        sz = m_bits[i].size();
        if (sz == PAT_LEN) begin
          win = '0;
          for (int k = 0; k < PAT_LEN; k++) win = {win[PAT_LEN-2:0], m_bits[i][k]};
          if (win == m_pat) begin
            e_hit[i] = 1'b1;
            if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
            if (!m_ovl) m_bits[i].delete();
          end
        end
      end
    end
    exp_q.push_back(e_hit);
  endtask

  task automatic check_outputs();
    logic [N_CH-1:0] e_hit;
    logic [N_CH-1:0] e_arm;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e_hit = exp_q.pop_front();
    check("hit", 32'(hit), 32'(e_hit));
    e_arm = '0;
    for (int i = 0; i < N_CH; i++) begin
      e_arm[i] = (m_bits[i].size() == PAT_LEN);
      if (hit[i] === 1'b1) tally[i]++;
    end
    check("armed", 32'(dbg_armed), 32'(e_arm));
`ifdef HIT_COUNT_EN
    for (int i = 0; i < N_CH; i++) begin
      check($sformatf("hit_cnt%0d", i), 32'(hit_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
    end
`endif
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step(input logic e, input logic [N_CH-1:0] xv,
                      input logic ld = 1'b0,
                      input logic [PAT_LEN-1:0] lp = '0,
                      input logic lo = 1'b1);
    en          = e;
    x           = xv;
    cfg_load    = ld;
    cfg_pattern = lp;
    cfg_overlap = lo;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_async_hit", 32'(hit), 32'd0);
    check("rst_async_armed", 32'(dbg_armed), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_hit", 32'(hit), 32'd0);
`ifdef HIT_COUNT_EN
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
    rst = 1'b1;
  endtask

  task automatic clear_tally();
    for (int i = 0; i < N_CH; i++) tally[i] = 0;
  endtask

  // Drives one bit sequence (MSB first) onto a single channel, others 0.
  task automatic send_ch(input int ch, input logic [15:0] bits, input int len);
    logic [N_CH-1:0] xv;
    for (int k = len - 1; k >= 0; k--) begin
      xv     = '0;
      xv[ch] = bits[k];
      step(1'b1, xv);
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [N_CH-1:0] xv;
    int r;
    rst = 1'b0; en = 1'b0; x = '0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b1;
    clear_tally();
    #2;
    do_reset();

    // 1: default pattern 1011, overlap on, shared-prefix second hit
    clear_tally();
    send_ch(0, 16'b1011011, 7);
    check("t1_hits_ch0", 32'(tally[0]), 32'd2);
    check("t1_hits_other", 32'(tally[1] + tally[2] + tally[3]), 32'd0);

    // 2: non-overlapping mode, same stream gives a single hit
    step(1'b1, '0, 1'b1, 4'b1011, 1'b0);
    clear_tally();
    send_ch(0, 16'b1011011, 7);
    check("t2_hits_ch0", 32'(tally[0]), 32'd1);

    // 3: reset discards a partial match
    step(1'b1, '0, 1'b1, 4'b1011, 1'b1);
    clear_tally();
    send_ch(0, 16'b101, 3);
    do_reset();
    send_ch(0, 16'b1, 1);
    check("t3_no_hit_after_rst", 32'(tally[0]), 32'd0);
    send_ch(0, 16'b011, 3);
    check("t3_hit_after_refill", 32'(tally[0]), 32'd1);

    // 4: en=0 gap inside a pattern
    step(1'b1, '0, 1'b1, 4'b1011, 1'b1);
    clear_tally();
    send_ch(0, 16'b101, 3);
    for (int k = 0; k < 3; k++) step(1'b0, N_CH'($urandom));
    check("t4_no_hit_in_gap", 32'(tally[0]), 32'd0);
    send_ch(0, 16'b1, 1);
    check("t4_one_hit", 32'(tally[0]), 32'd1);

    // 5: two channels offset by two cycles, then cfg_load mid-pattern on ch3
    step(1'b1, '0, 1'b1, 4'b1011, 1'b1);
    clear_tally();
    begin
      logic [3:0] s;
      s = 4'b1011;
      for (int c = 0; c < 6; c++) begin
        xv = '0;
        if (c < 4) xv[1] = s[3-c];
        if (c >= 2) xv[2] = s[5-c];
        step(1'b1, xv);
      end
    end
    check("t5_hit_ch1", 32'(tally[1]), 32'd1);
    check("t5_hit_ch2", 32'(tally[2]), 32'd1);
    send_ch(3, 16'b101, 3);
    step(1'b1, 4'b1000, 1'b1, 4'b1011, 1'b1);
    send_ch(3, 16'b1, 1);
    check("t5_ch3_no_hit", 32'(tally[3]), 32'd0);

`ifdef HIT_COUNT_EN
    // 6: saturating counter, pattern 1111 with x held high
    do_reset();
    step(1'b1, '0, 1'b1, 4'b1111, 1'b1);
    clear_tally();
    for (int k = 0; k < 10; k++) step(1'b1, 4'b0001);
    check("t6_hits", 32'(tally[0]), 32'd7);
    check("t6_cnt_sat", 32'(hit_cnt[CNT_W-1:0]), 32'd3);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0001);
    check("t6_cnt_hold", 32'(hit_cnt[CNT_W-1:0]), 32'd3);
`endif

    // Randomized run against the model
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 6) begin
        step(1'b1, N_CH'($urandom), 1'b1, PAT_LEN'($urandom), 1'($urandom));
      end else if (r < 16) begin
        step(1'b0, N_CH'($urandom));
      end else begin
        step(1'b1, N_CH'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
